// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-lane data memory controller between the core LSU and on-chip SRAM.
// Requests and responses use valid/ready handshakes with at most one request outstanding.
// Byte, half and word accesses are supported, with sign or zero extension on loads and
// selectable endianness. A misaligned access or an illegal size returns an error
// response and leaves the memory untouched.
module dmem_ctrl #(
    parameter int  DATA_WIDTH = 32,
    parameter int  LANE_WIDTH = 8,
    parameter int  ADDR_WIDTH = 14,
    parameter bit  BIG_ENDIAN = 1'b1,
    localparam int NUM_LANES  = DATA_WIDTH / LANE_WIDTH,
    localparam int OFS_W      = $clog2(NUM_LANES),
    localparam int SZ_W       = $clog2(OFS_W + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [SZ_W-1:0]       req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o
);

    localparam int WIDX_W = ADDR_WIDTH - OFS_W;
    localparam int DEPTH  = 2 ** WIDX_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_RSP   = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                         state;
    logic                           accept;
    logic [WIDX_W-1:0]              widx;

    // Request decode results
    logic                           req_err;
    logic [NUM_LANES-1:0]           lane_we;
    logic [NUM_LANES*LANE_WIDTH-1:0] lane_wdata;
    int                             w_nbytes;
    int                             w_ofs;
    int                             w_lane;
    int                             w_src;

    // Load/store attributes registered alongside the synchronous RAM read
    logic [OFS_W-1:0]               p_ofs;
    logic [SZ_W-1:0]                p_size;
    logic                           p_uns;
    logic                           p_err;
    logic                           p_we;

    // RAM read data, one lane per byte slot of the word
    logic [DATA_WIDTH-1:0]          rd_lanes;

    // Formatted response and the copy held under backpressure
    logic [DATA_WIDTH-1:0]          fmt_data;
    int                             r_nbytes;
    int                             r_ofs;
    int                             r_lane;
    int                             r_dst;
    logic                           r_sign;
    logic [DATA_WIDTH-1:0]          hold_data;
    logic                           hold_err;

    assign rsp_valid_o = (state != ST_EMPTY);
    assign req_ready_o = !rst && ((state == ST_EMPTY) || rsp_ready_i);
    assign accept      = req_valid_i && req_ready_o;
    assign widx        = req_addr_i[ADDR_WIDTH-1:OFS_W];

    // Alignment check and byte-lane write enables/data for the incoming request
    always_comb begin
        req_err    = 1'b0;
        lane_we    = '0;
        lane_wdata = '0;
        w_nbytes   = 1;
        w_ofs      = 0;
        w_lane     = 0;
        w_src      = 0;
        if (int'(req_size_i) > OFS_W) begin
            req_err = 1'b1;
        end else begin
            w_nbytes = 1 << int'(req_size_i);
            for (int b = 0; b < OFS_W; b++) begin
                if ((b < int'(req_size_i)) && req_addr_i[b]) begin
                    req_err = 1'b1;
                end else begin
                    req_err = req_err;
                end
            end
        end
        if (!req_err && req_we_i) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (k < w_nbytes) begin
                    w_ofs  = int'(req_addr_i[OFS_W-1:0]) + k;
                    w_lane = BIG_ENDIAN ? (NUM_LANES - 1 - w_ofs) : w_ofs;
                    w_src  = BIG_ENDIAN ? (w_nbytes - 1 - k) : k;
                    lane_we[w_lane] = 1'b1;
                    lane_wdata[w_lane*LANE_WIDTH +: LANE_WIDTH] =
                        req_wdata_i[w_src*LANE_WIDTH +: LANE_WIDTH];
                end else begin
                    lane_we = lane_we;
                end
            end
        end else begin
            lane_we = '0;
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [LANE_WIDTH-1:0] ram [DEPTH];
        logic [LANE_WIDTH-1:0] rd_q;

        // Lane RAM: write on an accepted store, synchronous read on every accept
        always_ff @(posedge clk) begin
            if (accept && lane_we[l]) begin
                ram[widx] <= lane_wdata[l*LANE_WIDTH +: LANE_WIDTH];
            end
            if (accept) begin
                rd_q <= ram[widx];
            end
        end

        assign rd_lanes[l*LANE_WIDTH +: LANE_WIDTH] = rd_q;
    end

    // Capture access attributes on accept so the response can be formatted later
    always_ff @(posedge clk) begin
        if (rst) begin
            p_ofs  <= '0;
            p_size <= '0;
            p_uns  <= 1'b0;
            p_err  <= 1'b0;
            p_we   <= 1'b0;
        end else if (accept) begin
            p_ofs  <= req_addr_i[OFS_W-1:0];
            p_size <= req_size_i;
            p_uns  <= req_unsigned_i;
            p_err  <= req_err;
            p_we   <= req_we_i;
        end
    end

    // Extract the addressed bytes, right-justify them and extend to the full word
    always_comb begin
        fmt_data = '0;
        r_nbytes = 1;
        r_ofs    = 0;
        r_lane   = 0;
        r_dst    = 0;
        r_sign   = 1'b0;
        if (!p_err && !p_we) begin
            r_nbytes = 1 << int'(p_size);
            for (int k = 0; k < NUM_LANES; k++) begin
                if (k < r_nbytes) begin
                    r_ofs  = int'(p_ofs) + k;
                    r_lane = BIG_ENDIAN ? (NUM_LANES - 1 - r_ofs) : r_ofs;
                    r_dst  = BIG_ENDIAN ? (r_nbytes - 1 - k) : k;
                    fmt_data[r_dst*LANE_WIDTH +: LANE_WIDTH] =
                        rd_lanes[r_lane*LANE_WIDTH +: LANE_WIDTH];
                end else begin
                    fmt_data = fmt_data;
                end
            end
            r_sign = fmt_data[r_nbytes*LANE_WIDTH-1] && !p_uns;
            for (int b = 0; b < DATA_WIDTH; b++) begin
                if (b >= r_nbytes*LANE_WIDTH) begin
                    fmt_data[b] = r_sign;
                end else begin
                    fmt_data[b] = fmt_data[b];
                end
            end
        end else begin
            fmt_data = '0;
        end
    end

    // Response FSM; the hold register freezes the response while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            hold_data <= '0;
            hold_err  <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready_i) begin
                        state <= accept ? ST_RSP : ST_EMPTY;
                    end else begin
                        state     <= ST_HOLD;
                        hold_data <= fmt_data;
                        hold_err  <= p_err;
                    end
                end
                ST_HOLD: begin
                    if (rsp_ready_i) begin
                        state <= accept ? ST_RSP : ST_EMPTY;
                    end
                end
                default: begin
                    state <= ST_EMPTY;
                end
            endcase
        end
    end

    // Output mux: live formatted data in RSP, frozen copy in HOLD, zero when idle
    always_comb begin
        case (state)
            ST_RSP: begin
                rsp_rdata_o = fmt_data;
                rsp_err_o   = p_err;
            end
            ST_HOLD: begin
                rsp_rdata_o = hold_data;
                rsp_err_o   = hold_err;
            end
            default: begin
                rsp_rdata_o = '0;
                rsp_err_o   = 1'b0;
            end
        endcase
    end

endmodule
